piece_dropper: RTL and testbench
================================

// Module: piece_dropper
// PURPOSE
//   Board-side writer for the column occupancy codes. Accepts a drop request
//   (column, player) and animates the piece falling one row per FALL_TICKS
//   cycles. It then commits the piece by extending that column's thermometer
//   occupancy code and its colour bit.
//   Sits between the game controller (requester) and the VGA drawing path
//   (consumer of anim_*, onoff_flat, color_flat).
// PARAMETERS
//   COLS       7  number of board columns
//   ROWS       6  slots per column (thermometer width)
//   FALL_TICKS 4  cycles each animation row is held (>=1)
//   CW         3  width of column index
//   RW         3  width of row index
// PORTS
//   clk          in   1          system clock, rising edge
//   resetn       in   1          asynchronous, active-low reset
//   drop_req     in   1          request; accepted only in a cycle with ready=1
//   drop_col     in   CW         target column, sampled on accept
//   drop_player  in   1          piece owner (0/1), sampled on accept
//   clear        in   1          synchronous board clear, highest priority
//   ready        out  1          1 only in IDLE
//   anim_valid   out  1          1 while in FALL
//   anim_col     out  CW         column of falling piece
//   anim_row     out  RW         current animation row
//   done         out  1          1-cycle pulse in COMMIT
//   done_row     out  RW         landing row, valid with done
//   reject       out  1          1-cycle pulse: bad column or column full
//   onoff_flat   out  COLS*ROWS  column c = [c*ROWS +: ROWS]; thermometer, bit0 fills first
//   color_flat   out  COLS*ROWS  per-slot owner, same indexing; meaningful where onoff=1
// BEHAVIOUR
//   Reset (resetn=0, async): state=IDLE, onoff_flat=0, color_flat=0, anim_*=0,
//     done=0, done_row=0, reject=0, tick counter=0; ready=1 once reset releases.
//   Occupancy codes are always of the form 0..01..1.
//   Landing row = number of ones in that column (0..ROWS-1).
//   Full column = all ones.
//   FSM IDLE -> FALL -> COMMIT -> IDLE.
//   IDLE:
//     - drop_req=1 and clear=0 with drop_col>=COLS or column full:
//       reject=1 the next cycle; stay IDLE; board unchanged.
//     - drop_req=1 and clear=0 with a valid request: latch col, player and
//       target=landing row; set anim_row=ROWS-1, tick=0; go to FALL.
//   FALL:
//     - anim_valid=1; tick counts 0..FALL_TICKS-1.
//     - At tick=FALL_TICKS-1: if anim_row==target go to COMMIT, else
//       decrement anim_row and set tick=0.
//     - Total FALL cycles = (ROWS-target)*FALL_TICKS.
//   COMMIT (one cycle):
//     - done=1, done_row=target.
//     - On the exiting edge, set onoff bit [col*ROWS+target] and color bit to
//       player. The new value is visible the cycle after done.
//     - Return to IDLE.
//   drop_req outside IDLE is ignored: no queueing, no reject.
//   clear=1 in any state: next cycle onoff/color=0, state=IDLE,
//     anim_valid=0, no done. An in-flight piece is discarded.
//     A drop_req in the same cycle is ignored.
//   Reset mid-FALL or mid-COMMIT: immediate return to reset values; no
//     partial commit.
//   anim_col/anim_row hold their last values outside FALL.
//   done and reject are never both 1.
// TESTING
//   - Reset, then drop col=3 player=1 -> anim_row steps 5,4,3,2,1,0, each held
//     4 cycles; done 25 cycles after accept, done_row=0; then column 3 bits=000001
//     and color bit [18]=1.
//   - Six drops in col 0 (players alternating, starting 0) -> done_row 0..5,
//     col0=111111, color=101010 (bit0=0, bit1=1). A seventh drop -> reject pulse,
//     board unchanged.
//   - Drop col=7 -> reject=1 one cycle later, ready stays 1, no anim_valid.
//   - Assert clear during FALL at anim_row=3 -> next cycle IDLE, board=0,
//     no done pulse.
//   - Hold drop_req high continuously in col 2 -> exactly one accept per
//     IDLE cycle; requests during FALL/COMMIT ignored; landing rows 0,1,2...
//   - Pulse resetn low mid-FALL -> all outputs zero asynchronously, ready=1
//     after release.

Source files
------------

// File: rtl/piece_dropper.sv
// Board-side column writer: accepts a drop, animates it down one row per FALL_TICKS cycles,
// then commits it into the column's thermometer occupancy code and colour bits.
module piece_dropper #(
  parameter int unsigned COLS       = 7,
  parameter int unsigned ROWS       = 6,
  parameter int unsigned FALL_TICKS = 4,
  parameter int unsigned CW         = 3,
  parameter int unsigned RW         = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 drop_req,
  input  logic [CW-1:0]        drop_col,
  input  logic                 drop_player,
  input  logic                 clear,
  output logic                 ready,
  output logic                 anim_valid,
  output logic [CW-1:0]        anim_col,
  output logic [RW-1:0]        anim_row,
  output logic                 done,
  output logic [RW-1:0]        done_row,
  output logic                 reject,
  output logic [COLS*ROWS-1:0] onoff_flat,
  output logic [COLS*ROWS-1:0] color_flat
);

  localparam int unsigned TW = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;

  typedef enum logic [1:0] {StIdle, StFall, StCommit} state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         tick_q;
  logic [CW-1:0]         col_q;
  logic [RW-1:0]         row_q;
  logic [RW-1:0]         target_q;
  logic                  player_q;
  logic                  reject_q;
  logic [COLS*ROWS-1:0]  onoff_q, color_q;

  logic [ROWS-1:0]       sel_col;
  logic [RW-1:0]         land_row;
  logic                  col_ok, col_full, req_idle, accept, bad_req, tick_last;
  logic [COLS*ROWS-1:0]  commit_mask;

  // Occupancy of the requested column; out-of-range columns read as empty.
  always_comb begin
    sel_col  = '0;
    land_row = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (drop_col == CW'(c)) sel_col = onoff_q[c*ROWS +: ROWS];
    end
    for (int unsigned r = 0; r < ROWS; r++) begin
      land_row = land_row + RW'(sel_col[r]);
    end
  end

  always_comb begin
    col_ok    = 32'(drop_col) < COLS;
    col_full  = &sel_col;
    req_idle  = (state_q == StIdle) && drop_req && !clear;
    accept    = req_idle && col_ok && !col_full;
    bad_req   = req_idle && !(col_ok && !col_full);
    tick_last = tick_q == TW'(FALL_TICKS - 1);
    for (int unsigned i = 0; i < COLS*ROWS; i++) begin
      commit_mask[i] = (32'(col_q) * ROWS + 32'(target_q)) == i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StFall;
      StFall:   if (tick_last && row_q == target_q) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (clear) state_d = StIdle;
  end

  always_comb begin
    ready      = state_q == StIdle;
    anim_valid = state_q == StFall;
    done       = state_q == StCommit;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      target_q <= '0;
      player_q <= 1'b0;
      reject_q <= 1'b0;
      onoff_q  <= '0;
      color_q  <= '0;
    end else begin
      reject_q <= bad_req;
      if (clear) begin
        tick_q  <= '0;
        onoff_q <= '0;
        color_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (accept) begin
              col_q    <= drop_col;
              player_q <= drop_player;
              target_q <= land_row;
              row_q    <= RW'(ROWS - 1);
              tick_q   <= '0;
            end
          end
          StFall: begin
            if (tick_last) begin
              tick_q <= '0;
              if (row_q != target_q) row_q <= row_q - RW'(1);
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
          StCommit: begin
            onoff_q <= onoff_q | commit_mask;
            color_q <= (color_q & ~commit_mask) | (player_q ? commit_mask : '0);
          end
          default: ;
        endcase
      end
    end
  end

  assign anim_col   = col_q;
  assign anim_row   = row_q;
  assign done_row   = target_q;
  assign reject     = reject_q;
  assign onoff_flat = onoff_q;
  assign color_flat = color_q;

endmodule

// File: tb/tb_piece_dropper.sv
// Bench for piece_dropper: cycle-level timing model plus directed scenarios with literal checks.
module tb_piece_dropper;
  localparam int COLS = 7;
  localparam int ROWS = 6;
  localparam int FT   = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        drop_req = 1'b0;
  logic [2:0]  drop_col = '0;
  logic        drop_player = 1'b0;
  logic        clear = 1'b0;
  logic        ready, anim_valid, done, reject;
  logic [2:0]  anim_col, anim_row, done_row;
  logic [41:0] onoff_flat, color_flat;

  int errors = 0;
  int checks = 0;

  piece_dropper dut (
    .clk        (clk),
    .resetn     (resetn),
    .drop_req   (drop_req),
    .drop_col   (drop_col),
    .drop_player(drop_player),
    .clear      (clear),
    .ready      (ready),
    .anim_valid (anim_valid),
    .anim_col   (anim_col),
    .anim_row   (anim_row),
    .done       (done),
    .done_row   (done_row),
    .reject     (reject),
    .onoff_flat (onoff_flat),
    .color_flat (color_flat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: per-column piece counts and owners; a transaction is timed by cycles since accept.
  int          m_cnt [0:7];
  logic [5:0]  m_color [0:7];
  bit          m_busy, m_rej;
  int          m_el, m_tgt, m_col, m_row, m_lcol;
  bit          m_player;

  function automatic int fall_len(input int tgt);
    return (ROWS - tgt) * FT;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy <= 0; m_rej <= 0; m_el <= 0; m_tgt <= 0; m_col <= 0;
      m_row <= 0; m_lcol <= 0; m_player <= 0;
      for (int c = 0; c < 8; c++) begin m_cnt[c] <= 0; m_color[c] <= '0; end
    end else begin
      m_rej <= 0;
      if (clear) begin
        m_busy <= 0;
        for (int c = 0; c < 8; c++) begin m_cnt[c] <= 0; m_color[c] <= '0; end
      end else if (m_busy) begin
        if (m_el == fall_len(m_tgt) + 1) begin
          m_busy <= 0;
          m_cnt[m_col] <= m_cnt[m_col] + 1;
          m_color[m_col][m_tgt] <= m_player;
        end else begin
          m_el <= m_el + 1;
          if (m_el + 1 <= fall_len(m_tgt)) m_row <= ROWS - 1 - m_el / FT;
        end
      end else if (drop_req) begin
        if (int'(drop_col) >= COLS || m_cnt[drop_col] == ROWS) m_rej <= 1;
        else begin
          m_busy <= 1; m_el <= 1; m_tgt <= m_cnt[drop_col];
          m_col <= int'(drop_col); m_lcol <= int'(drop_col);
          m_player <= drop_player; m_row <= ROWS - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [41:0] e_on, e_co;
    bit fall, comm;
    e_on = '0; e_co = '0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) begin
        e_on[c*ROWS+r] = (r < m_cnt[c]);
        e_co[c*ROWS+r] = m_color[c][r];
      end
    fall = m_busy && m_el <= fall_len(m_tgt);
    comm = m_busy && m_el == fall_len(m_tgt) + 1;
    chk("m_ready", 64'(ready), 64'(!m_busy));
    chk("m_anim_valid", 64'(anim_valid), 64'(fall));
    chk("m_done", 64'(done), 64'(comm));
    chk("m_reject", 64'(reject), 64'(m_rej));
    chk("m_anim_col", 64'(anim_col), 64'(m_lcol));
    chk("m_anim_row", 64'(anim_row), 64'(m_row));
    chk("m_onoff", 64'(onoff_flat), 64'(e_on));
    chk("m_color", 64'(color_flat), 64'(e_co));
    if (comm) chk("m_done_row", 64'(done_row), 64'(m_tgt));
    if (done && reject) chk("done_and_reject", 64'(1), 64'(0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one drop from IDLE; returns cycles from accept to done and the done_row seen.
  task automatic do_drop(input int c, input bit p, output int lat, output int row);
    drop_req = 1; drop_col = 3'(c); drop_player = p;
    step();
    drop_req = 0;
    lat = 1;
    while (!done && lat < 100) begin step(); lat++; end
    if (!done) chk("done_timeout", 64'(0), 64'(1));
    row = int'(done_row);
    step();
  endtask

  initial begin
    int lat, row, n;
    int rows_seen [$];
    step(); step();
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_onoff", 64'(onoff_flat), 64'(0));
    chk("rst_anim", 64'({anim_valid, anim_col, anim_row}), 64'(0));
    resetn = 1;
    step();
    chk("ready_after_rst", 64'(ready), 64'(1));

    // Single drop into column 3.
    do_drop(3, 1, lat, row);
    chk("c3_latency", 64'(lat), 64'(25));
    chk("c3_done_row", 64'(row), 64'(0));
    chk("c3_bits", 64'(onoff_flat[23:18]), 64'(6'b000001));
    chk("c3_color18", 64'(color_flat[18]), 64'(1));

    // Fill column 0 with alternating players.
    for (int i = 0; i < 6; i++) begin
      do_drop(0, i[0], lat, row);
      chk("c0_done_row", 64'(row), 64'(i));
      chk("c0_latency", 64'(lat), 64'((6 - i) * 4 + 1));
    end
    chk("c0_bits", 64'(onoff_flat[5:0]), 64'(6'b111111));
    chk("c0_color", 64'(color_flat[5:0]), 64'(6'b101010));
    drop_req = 1; drop_col = 0; drop_player = 0;
    step();
    drop_req = 0;
    chk("full_reject", 64'(reject), 64'(1));
    chk("full_no_anim", 64'(anim_valid), 64'(0));
    step();
    chk("full_reject_pulse", 64'(reject), 64'(0));
    chk("full_board", 64'(onoff_flat[5:0]), 64'(6'b111111));

    // Out-of-range column.
    drop_req = 1; drop_col = 3'd7;
    step();
    drop_req = 0;
    chk("col7_reject", 64'(reject), 64'(1));
    chk("col7_ready", 64'(ready), 64'(1));
    chk("col7_anim", 64'(anim_valid), 64'(0));
    step();

    // Clear in the middle of a fall.
    drop_req = 1; drop_col = 3'd4; drop_player = 1;
    step();
    drop_req = 0;
    n = 0;
    while (anim_row != 3'd3 && n < 50) begin step(); n++; end
    chk("clr_reach_row3", 64'(anim_row), 64'(3));
    clear = 1; drop_req = 1; drop_col = 3'd1;
    step();
    clear = 0; drop_req = 0;
    chk("clr_ready", 64'(ready), 64'(1));
    chk("clr_anim", 64'(anim_valid), 64'(0));
    chk("clr_onoff", 64'(onoff_flat), 64'(0));
    chk("clr_color", 64'(color_flat), 64'(0));
    n = 0;
    for (int i = 0; i < 30; i++) begin step(); n += int'(done); end
    chk("clr_no_done", 64'(n), 64'(0));

    // Continuous request in column 2.
    drop_req = 1; drop_col = 3'd2; drop_player = 0;
    for (int i = 0; i < 80 && rows_seen.size() < 3; i++) begin
      step();
      if (done) rows_seen.push_back(int'(done_row));
    end
    drop_req = 0;
    chk("hold_count", 64'(rows_seen.size()), 64'(3));
    for (int i = 0; i < rows_seen.size(); i++) chk("hold_row", 64'(rows_seen[i]), 64'(i));
    n = 0;
    while (!ready && n < 40) begin step(); n++; end
    step();

    // Asynchronous reset in the middle of a fall.
    drop_req = 1; drop_col = 3'd5; drop_player = 1;
    step();
    drop_req = 0;
    repeat (6) step();
    chk("pre_rst_anim", 64'(anim_valid), 64'(1));
    #2 resetn = 0;
    #1;
    chk("arst_anim", 64'({anim_valid, anim_col, anim_row}), 64'(0));
    chk("arst_onoff", 64'(onoff_flat), 64'(0));
    chk("arst_pulses", 64'({done, reject, done_row}), 64'(0));
    step();
    resetn = 1;
    step();
    chk("arst_ready", 64'(ready), 64'(1));
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
